// File: rtl/csi2_delay_calib.sv
// CSI-2 D-PHY input delay calibration: sweeps every tap, scores each one from
// receiver error pulses, then steps the delay line to the centre of the widest clean window.
module csi2_delay_calib #(
    parameter int DATA_LANES     = 2,
    parameter int TAPS           = 32,
    parameter int FRAMES_PER_TAP = 2,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1 << 20,
    localparam int TAP_W         = $clog2(TAPS),
    localparam int LEN_W         = $clog2(TAPS + 1)
) (
    input  logic                  clk_i,
    input  logic                  srst_i,
    input  logic                  start_i,
    input  logic [DATA_LANES-1:0] lane_mask_i,
    input  logic                  frame_start_i,
    input  logic                  frame_end_i,
    input  logic                  header_err_i,
    input  logic                  crc_err_i,
    output logic                  delay_act_o,
    output logic [DATA_LANES-1:0] lane_delay_o,
    output logic [TAP_W-1:0]      cur_tap_o,
    output logic [TAP_W-1:0]      best_tap_o,
    output logic [LEN_W-1:0]      best_len_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [2:0]            state_o
);

    localparam int FRM_W = $clog2(FRAMES_PER_TAP + 1);
    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SUM_W = LEN_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_WAIT_SOF, S_MEASURE, S_SCORE, S_INC, S_STEP, S_FINISH
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_LANES-1:0] mask_q;
    logic [TAP_W-1:0]      cur_tap_q;
    logic [SET_W-1:0]      settle_cnt_q;
    logic [TMO_W-1:0]      timer_q;
    logic [FRM_W-1:0]      frame_cnt_q;
    logic                  tap_good_q;
    logic [LEN_W-1:0]      run_len_q, best_len_q;
    logic [TAP_W-1:0]      run_start_q, best_start_q;
    logic                  step_gap_q;
    logic                  done_q, fail_q;

    logic                  delay_act;
    logic                  settle_done, timed_out, meas_err, last_frame, good_now;
    logic                  at_target;
    logic [TAP_W-1:0]      best_tap;
    logic [SUM_W-1:0]      best_sum;
    logic [LEN_W-1:0]      run_len_inc;

    function automatic logic [TAP_W-1:0] tap_inc(input logic [TAP_W-1:0] t);
        if (t == TAP_W'(TAPS - 1)) return '0;
        return t + TAP_W'(1);
    endfunction

    // Centre of the best window; best_start/best_len are cleared on start, so 0 when nothing passed.
    assign best_sum    = SUM_W'(best_start_q) + SUM_W'(best_len_q >> 1);
    assign best_tap    = best_sum[TAP_W-1:0];
    assign run_len_inc = run_len_q + LEN_W'(1);

    assign settle_done = (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1));
    assign timed_out   = (timer_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign meas_err    = header_err_i | crc_err_i;
    assign last_frame  = frame_end_i && (frame_cnt_q == FRM_W'(FRAMES_PER_TAP - 1));
    assign good_now    = last_frame && !meas_err && !timed_out;
    assign at_target   = (cur_tap_q == best_tap);

    always_comb begin
        state_d   = state_q;
        delay_act = 1'b0;
        case (state_q)
            S_IDLE:     if (start_i) state_d = S_SETTLE;
            S_SETTLE:   if (settle_done) state_d = S_WAIT_SOF;
            S_WAIT_SOF: begin
                if (timed_out)          state_d = S_SCORE;
                else if (frame_start_i) state_d = S_MEASURE;
            end
            S_MEASURE:  if (meas_err || timed_out || last_frame) state_d = S_SCORE;
            S_SCORE:    state_d = (cur_tap_q == TAP_W'(TAPS - 1)) ? S_STEP : S_INC;
            S_INC: begin
                delay_act = 1'b1;
                state_d   = S_SETTLE;
            end
            // Stepping alternates strobe and gap cycles so the PHY sees distinct increments.
            S_STEP: begin
                if (at_target)        state_d   = S_FINISH;
                else if (!step_gap_q) delay_act = 1'b1;
            end
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            cur_tap_q    <= '0;
            settle_cnt_q <= '0;
            timer_q      <= '0;
            frame_cnt_q  <= '0;
            tap_good_q   <= 1'b0;
            run_len_q    <= '0;
            run_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
            step_gap_q   <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (delay_act) cur_tap_q <= tap_inc(cur_tap_q);
            settle_cnt_q <= (state_q == S_SETTLE) ? settle_cnt_q + SET_W'(1) : '0;
            timer_q      <= (state_q == S_WAIT_SOF || state_q == S_MEASURE) ? timer_q + TMO_W'(1) : '0;
            if (state_q != S_MEASURE)  frame_cnt_q <= '0;
            else if (frame_end_i)      frame_cnt_q <= frame_cnt_q + FRM_W'(1);
            // Only meaningful on the edge that enters SCORE, where it carries the tap verdict.
            tap_good_q   <= (state_q == S_MEASURE) && good_now;
            step_gap_q   <= (state_q == S_STEP && !at_target) ? !step_gap_q : 1'b0;

            if (state_q == S_IDLE && start_i) begin
                mask_q       <= lane_mask_i;
                done_q       <= 1'b0;
                fail_q       <= 1'b0;
                run_len_q    <= '0;
                run_start_q  <= '0;
                best_len_q   <= '0;
                best_start_q <= '0;
            end

            if (state_q == S_SCORE) begin
                if (tap_good_q) begin
                    if (run_len_q == '0) run_start_q <= cur_tap_q;
                    run_len_q <= run_len_inc;
                    // Strict compare keeps the earliest of equally long windows.
                    if (run_len_inc > best_len_q) begin
                        best_len_q   <= run_len_inc;
                        best_start_q <= (run_len_q == '0) ? cur_tap_q : run_start_q;
                    end
                end else begin
                    run_len_q <= '0;
                end
            end

            if (state_q == S_STEP && at_target) begin
                done_q <= (best_len_q != '0);
                fail_q <= (best_len_q == '0);
            end
        end
    end

    assign delay_act_o  = delay_act;
    assign lane_delay_o = delay_act ? mask_q : '0;
    assign cur_tap_o    = delay_act ? tap_inc(cur_tap_q) : cur_tap_q;
    assign best_tap_o   = best_tap;
    assign best_len_o   = best_len_q;
    assign busy_o       = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign state_o      = state_q;

endmodule
